mul_k_sched: RTL and testbench
==============================

MUL_K_SCHED -- requirements
Module: mul_k_sched

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the multiplier, 2..8.
REQ-002 Parameter MUL_LAT, default 3: pipeline depth of the attached 16x20 multiplier in clock edges, 1..8.
REQ-003 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 sched_en  in  1  grant enable; low blocks new grants.
REQ-006 req_valid  in  N_REQ  per-requester operation request.
REQ-007 req_a  in  N_REQ*16  packed operand A per requester (sqrt_poly path).
REQ-008 req_b  in  N_REQ*20  packed operand B per requester (coefficient K).
REQ-009 req_ready  out  N_REQ  per-requester accept, at most one bit high.
REQ-010 mul_a  out  16  operand A to multiplier.
REQ-011 mul_b  out  20  operand B to multiplier.
REQ-012 mul_p  in  30  product from multiplier.
REQ-013 rsp_valid  out  1  result valid, single-cycle pulse per result.
REQ-014 rsp_id  out  3  index of requester owning the result.
REQ-015 rsp_p  out  30  product bits [29:0].
REQ-016 busy  out  1  high while any accepted operation has not yet produced rsp_valid.

Function
REQ-017 Acceptance SHALL occur on an edge where req_valid[i] and req_ready[i] are both high; at most one acceptance per edge.
REQ-018 req_ready SHALL be combinational from req_valid, sched_en and arbiter state; all zero when sched_en low or no request is pending.
REQ-019 Requesters SHALL hold req_valid and operands stable until accepted; the block SHALL never stall, so back-to-back acceptances on consecutive edges are permitted.
REQ-020 On acceptance at edge E0, mul_a/mul_b SHALL present that requester's operands from E0 until the next acceptance; when idle they SHALL hold their last value.
REQ-021 A valid/id tag pipeline of depth MUL_LAT+1 SHALL track each acceptance; rsp_valid, rsp_id and the registered rsp_p (mul_p sampled) SHALL assert after edge E0+MUL_LAT+1 for exactly one cycle.
REQ-022 rsp_p SHALL be zero whenever rsp_valid is low.
REQ-023 Results SHALL be returned in acceptance order; no result backpressure exists.
REQ-024 busy SHALL be the OR of all tag-pipeline valid bits (including the cycle rsp_valid is high).
REQ-025 sched_en deasserting SHALL not cancel in-flight operations; they complete normally.
REQ-026 Requester indices at or above N_REQ do not exist; rsp_id upper unused bits SHALL be zero.

Reset
REQ-027 While rst_n is low: req_ready=0, rsp_valid=0, rsp_id=0, rsp_p=0, mul_a=0, mul_b=0, busy=0, tag pipeline cleared, round-robin pointer=0.
REQ-028 Reset mid-operation SHALL drop all in-flight results; the multiplier's unreset pipeline contents SHALL never produce rsp_valid.
REQ-029 First acceptance is possible on the first rising edge after rst_n is released.

Configuration
REQ-030 With MUL_K_SCHED_RR_EN defined: round-robin arbitration; pointer moves to (granted index + 1) mod N_REQ after each acceptance; search starts at pointer.
REQ-031 Without MUL_K_SCHED_RR_EN: fixed priority, lowest index wins; pointer logic absent.

Structure
REQ-032 Shared package mul_k_pkg SHALL hold operand/product width constants (16, 20, 30), ID width 3 and the tag struct (valid, id).
REQ-033 Tag delay line SHALL be a separate sub-module mul_k_tag_pipe (parameter depth, async active-low reset); multiplier instance lives outside this block.

Verification
REQ-034 Single request: req_valid=4'b0001, a=16'd3, b=20'd5 -> req_ready[0] one cycle; rsp_valid with rsp_id=0, rsp_p=30'd15 after edge E0+4 (MUL_LAT=3).
REQ-035 RR: all four valid held 8 cycles -> grant order 0,1,2,3,0,1,2,3; results in same order, one per cycle; without macro all eight grants go to 0.
REQ-036 Max operands: a=16'hFFFF, b=20'h000FF -> rsp_p=30'h00FEFF01; verify no truncation for in-range products.
REQ-037 sched_en dropped one cycle after two back-to-back acceptances -> req_ready=0 thereafter, both results still delivered, busy falls the cycle after the second rsp_valid.
REQ-038 rst_n pulsed low with three operations in flight -> no rsp_valid after release, busy=0, outputs all zero, next request served from index 0.

Source files
------------

// File: rtl/mul_k_pkg.sv
// Shared widths and tag type for the multiplier scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mul_k_pkg;

    localparam int A_W  = 16;   // operand A width
    localparam int B_W  = 20;   // operand B (coefficient K) width
    localparam int P_W  = 30;   // product width returned to requesters
    localparam int ID_W = 3;    // requester index width (up to 8 requesters)

    // Per-operation tracking tag carried alongside the multiplier pipeline.
    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/mul_k_tag_pipe.sv
// Fixed-depth delay line for operation tags, tracking the multiplier pipeline.
// Latency: DEPTH edges from tag_i to tag_o.
// Backpressure: none; shifts on every edge, reset discards all tags.
module mul_k_tag_pipe
    import mul_k_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t tag_i,
    output tag_t tag_o,
    output logic any_vld_o
);

    tag_t stage_q [DEPTH];

    // Advance every tag one stage per edge; reset drops everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    // Any occupied stage means an accepted operation is still outstanding.
    always_comb begin
        any_vld_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_vld_o = any_vld_o | stage_q[i].vld;
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/mul_k_sched.sv
// Arbitrates N_REQ requesters onto one external pipelined 16x20 multiplier.
// Latency: result returned after edge E0+MUL_LAT+1 for acceptance at edge E0.
// Backpressure: never stalls; req_ready is the only flow control, no result backpressure.
// Optional MUL_K_SCHED_RR_EN selects round-robin arbitration (default: fixed priority, index 0 highest).
module mul_k_sched
    import mul_k_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int MUL_LAT = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sched_en,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*A_W-1:0]   req_a,
    input  logic [N_REQ*B_W-1:0]   req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic [A_W-1:0]         mul_a,
    output logic [B_W-1:0]         mul_b,
    input  logic [P_W-1:0]         mul_p,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [P_W-1:0]         rsp_p,
    output logic                   busy
);

    logic [ID_W-1:0] grant_idx;
    logic            grant_found;
    logic            accept;
    logic [A_W-1:0]  sel_a;
    logic [B_W-1:0]  sel_b;
    logic [A_W-1:0]  mul_a_q;
    logic [B_W-1:0]  mul_b_q;
    logic            rsp_valid_q;
    logic [ID_W-1:0] rsp_id_q;
    logic [P_W-1:0]  rsp_p_q;
    tag_t            tag_in;
    tag_t            tag_out;
    logic            pipe_busy;

`ifdef MUL_K_SCHED_RR_EN
    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;
    logic [ID_W-1:0] hi_idx;
    logic            hi_found;
    logic [ID_W-1:0] lo_idx;
    logic            lo_found;

    // Round-robin: first requester at or above the pointer, else wrap to the lowest one.
    always_comb begin
        hi_idx   = '0;
        hi_found = 1'b0;
        lo_idx   = '0;
        lo_found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i] && !lo_found) begin
                lo_idx   = ID_W'(i);
                lo_found = 1'b1;
            end
            if (req_valid[i] && !hi_found && (ID_W'(i) >= ptr_q)) begin
                hi_idx   = ID_W'(i);
                hi_found = 1'b1;
            end
        end
        grant_found = lo_found;
        grant_idx   = hi_found ? hi_idx : lo_idx;
        ptr_d       = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end

    // Pointer moves past the winner only when a grant is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (accept) begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority: lowest-numbered valid requester wins.
    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i] && !grant_found) begin
                grant_idx   = ID_W'(i);
                grant_found = 1'b1;
            end
        end
    end
`endif

    // Every valid winner is accepted immediately unless scheduling is disabled or in reset.
    assign accept = grant_found & sched_en & rst_n;

    // One-hot ready towards the winner and operand selection for the multiplier.
    always_comb begin
        req_ready = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                req_ready[i] = accept;
                sel_a        = req_a[i*A_W +: A_W];
                sel_b        = req_b[i*B_W +: B_W];
            end
        end
    end

    // Operand registers: load on acceptance, otherwise hold the last operation's values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a_q <= '0;
            mul_b_q <= '0;
        end else if (accept) begin
            mul_a_q <= sel_a;
            mul_b_q <= sel_b;
        end
    end

    assign tag_in.vld = accept;
    assign tag_in.id  = accept ? grant_idx : '0;

    // One extra stage beyond the multiplier depth aligns the tag with mul_p for capture.
    mul_k_tag_pipe #(
        .DEPTH (MUL_LAT + 1)
    ) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .tag_i     (tag_in),
        .tag_o     (tag_out),
        .any_vld_o (pipe_busy)
    );

    // Result register: capture the product only for a tracked operation, zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_p_q     <= '0;
        end else begin
            rsp_valid_q <= tag_out.vld;
            rsp_id_q    <= tag_out.vld ? tag_out.id : '0;
            rsp_p_q     <= tag_out.vld ? mul_p : '0;
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_p     = rsp_p_q;
    assign busy      = pipe_busy | rsp_valid_q;

endmodule

// File: tb/tb_mul_k_sched.sv
// Self-checking bench for mul_k_sched with a behavioural multiplier and scoreboard.
// Latency: checks results MUL_LAT+1 edges after each acceptance.
// Backpressure: requesters hold valid and operands until granted.
module tb_mul_k_sched;

    localparam int N   = 4;
    localparam int LAT = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            sched_en = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*16-1:0] req_a;
    logic [N*20-1:0] req_b;
    logic [N-1:0]    req_ready;
    logic [15:0]     mul_a;
    logic [19:0]     mul_b;
    logic [29:0]     mul_p;
    logic            rsp_valid;
    logic [2:0]      rsp_id;
    logic [29:0]     rsp_p;
    logic            busy;

    logic [15:0] op_a [N];
    logic [19:0] op_b [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign req_a[gi*16 +: 16] = op_a[gi];
        assign req_b[gi*20 +: 20] = op_b[gi];
    end

    mul_k_sched #(.N_REQ(N), .MUL_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .sched_en(sched_en),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: LAT edges deep, never reset, keeps low 30 bits.
    logic [35:0] full_prod;
    logic [29:0] mpipe [LAT];
    assign full_prod = {20'd0, mul_a} * {16'd0, mul_b};
    assign mul_p     = mpipe[LAT-1];
    always @(posedge clk) begin
        mpipe[0] <= full_prod[29:0];
        for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
    end

    // Scoreboard state
    typedef struct {
        int          id;
        logic [29:0] p;
        int          due;
    } exp_t;
    exp_t        q[$];
    int          edge_n = 0;
    int          ptr_m = 0;
    logic [15:0] last_a = '0;
    logic [19:0] last_b = '0;
    logic        obs_v;
    logic [2:0]  obs_id;
    logic [29:0] obs_p;
    logic [N-1:0] obs_rdy;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Which requester the arbitration rules pick, or -1 for none.
    function automatic int model_pick(input logic [N-1:0] v, input logic en, input int ptr);
        logic [N-1:0] t;
        if (!en || v == '0) return -1;
        for (int k = 0; k < N; k++) begin
`ifdef MUL_K_SCHED_RR_EN
            t = v >> ((ptr + k) % N);
            if (t[0]) return (ptr + k) % N;
`else
            t = v >> k;
            if (t[0]) return k;
`endif
        end
        return -1;
    endfunction

    function automatic logic [29:0] model_prod(input logic [15:0] a, input logic [19:0] b);
        logic [35:0] p;
        p = {20'd0, a} * {16'd0, b};
        return p[29:0];
    endfunction

    // One clock: drive, check ready, advance model, check registered outputs.
    task automatic cycle(input logic [N-1:0] v, input logic en);
        int g;
        logic [N-1:0] exp_rdy;
        logic exp_v;
        exp_t e;
        req_valid = v;
        sched_en  = en;
        #1;
        g = model_pick(v, en, ptr_m);
        exp_rdy = (g < 0) ? '0 : (N'(1) << g);
        obs_rdy = req_ready;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        @(posedge clk);
        edge_n++;
        if (g >= 0) begin
            e.id  = g;
            e.p   = model_prod(op_a[g], op_b[g]);
            e.due = edge_n + LAT + 1;
            q.push_back(e);
            last_a = op_a[g];
            last_b = op_b[g];
            ptr_m  = (g + 1) % N;
        end
        @(negedge clk);
        exp_v = (q.size() > 0) && (q[0].due == edge_n);
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_v));
        chk("rsp_id", 64'(rsp_id), exp_v ? 64'(q[0].id) : 64'd0);
        chk("rsp_p", 64'(rsp_p), exp_v ? 64'(q[0].p) : 64'd0);
        chk("busy", 64'(busy), 64'(q.size() > 0));
        chk("mul_a", 64'(mul_a), 64'(last_a));
        chk("mul_b", 64'(mul_b), 64'(last_b));
        obs_v  = rsp_valid;
        obs_id = rsp_id;
        obs_p  = rsp_p;
        if (exp_v) void'(q.pop_front());
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
        chk({tag, "_rsp_p"}, 64'(rsp_p), 64'd0);
        chk({tag, "_mul_a"}, 64'(mul_a), 64'd0);
        chk({tag, "_mul_b"}, 64'(mul_b), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    // Asynchronous reset pulse mid-cycle, released on a falling edge.
    task automatic do_reset();
        #2;
        rst_n     = 1'b0;
        req_valid = '1;
        sched_en  = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        q.delete();
        ptr_m  = 0;
        last_a = '0;
        last_b = '0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst_hold");
        req_valid = '0;
        rst_n     = 1'b1;
    endtask

    typedef struct {
        int          idx;
        logic [15:0] a;
        logic [19:0] b;
        logic [29:0] p;
    } vec_t;
    vec_t tbl [7];

    logic [N-1:0] pend;
    int           g0;
    int           exp_g;

    initial begin
        tbl[0] = '{0, 16'd3,     20'd5,       30'd15};
        tbl[1] = '{2, 16'hFFFF,  20'h000FF,   30'h00FEFF01};
        tbl[2] = '{1, 16'd1000,  20'd1000,    30'd1000000};
        tbl[3] = '{3, 16'h8000,  20'h00008,   30'h00040000};
        tbl[4] = '{1, 16'd0,     20'hABCDE,   30'd0};
        tbl[5] = '{3, 16'd12345, 20'd1000,    30'd12345000};
        tbl[6] = '{0, 16'hFFFF,  20'hFFFFF,   30'h3FEF0001};
        for (int i = 0; i < N; i++) begin
            op_a[i] = 16'(i + 1);
            op_b[i] = 20'(16 * (i + 1));
        end

        // Reset state with every requester asking
        req_valid = '1;
        sched_en  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        req_valid = '0;
        rst_n     = 1'b1;

        // Single-request vectors: exact product, id and latency
        for (int t = 0; t < 7; t++) begin
            op_a[tbl[t].idx] = tbl[t].a;
            op_b[tbl[t].idx] = tbl[t].b;
            cycle(N'(1) << tbl[t].idx, 1'b1);
            for (int k = 0; k < LAT + 1; k++) cycle('0, 1'b1);
            chk("tbl_rsp_valid", 64'(obs_v), 64'd1);
            chk("tbl_rsp_id", 64'(obs_id), 64'(tbl[t].idx));
            chk("tbl_rsp_p", 64'(obs_p), 64'(tbl[t].p));
        end

        // All four held: grant order depends on arbitration mode
        do_reset();
        for (int i = 0; i < N; i++) begin
            op_a[i] = 16'(100 + i);
            op_b[i] = 20'(7 * (i + 3));
        end
        for (int k = 0; k < 8; k++) begin
`ifdef MUL_K_SCHED_RR_EN
            exp_g = k % N;
`else
            exp_g = 0;
`endif
            cycle('1, 1'b1);
            chk("grant_order", 64'(obs_rdy), 64'(N'(1) << exp_g));
        end
        for (int k = 0; k < LAT + 3; k++) cycle('0, 1'b1);

        // Two back-to-back acceptances then scheduling disabled
        cycle(4'b0011, 1'b1);
        cycle(4'b0011, 1'b1);
        for (int k = 0; k < LAT + 4; k++) begin
            cycle(4'b0011, 1'b0);
            chk("sched_off_ready", 64'(obs_rdy), 64'd0);
        end
        chk("sched_off_idle", 64'(busy), 64'd0);

        // Reset with three operations in flight
        cycle(4'b0111, 1'b1);
        cycle(4'b0111, 1'b1);
        cycle(4'b0111, 1'b1);
        do_reset();
        for (int k = 0; k < LAT + 3; k++) begin
            cycle('0, 1'b1);
            chk("post_rst_no_rsp", 64'(obs_v), 64'd0);
        end
        cycle('1, 1'b1);
        chk("post_rst_grant0", 64'(obs_rdy), 64'd1);
        for (int k = 0; k < LAT + 2; k++) cycle('0, 1'b1);

        // Randomised traffic: requesters hold until granted
        pend = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    op_a[i] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
                    op_b[i] = 20'($urandom);
                end
            end
            sched_en = ($urandom_range(0, 4) != 0);
            g0 = model_pick(pend, sched_en, ptr_m);
            cycle(pend, sched_en);
            if (g0 >= 0) pend[g0] = 1'b0;
        end
        for (int k = 0; k < LAT + 3; k++) cycle('0, 1'b1);
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
